ss_digit_scanner: RTL and testbench

- Multi-digit BCD counter with a time-multiplexed scan driver, directly upstream of the team's 4-bit seven-segment decoder.
- Holds DIGITS BCD digits and presents one digit at a time as a 4-bit code on `digit`, which feeds the decoder's `in` input.
- Drives a one-hot digit-select for the common pins, plus a blank flag for leading-zero suppression.
- Provides load, clear and increment controls, and a wrap carry so instances can be chained.

---
 rtl/ss_digit_scanner.sv | 149 ++++++++++++++
 tb/tb_ss_digit_scanner.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_digit_scanner.sv
// ss_digit_scanner: DIGITS-digit BCD counter with a time-multiplexed scan
// driver that feeds a 4-bit seven-segment decoder. The counter supports
// clear, load and increment. The scanner presents one digit at a time, with
// a one-hot common select and optional leading-zero blanking.
module ss_digit_scanner #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_bcd,
    input  logic                  inc,
    output logic [3:0]            digit,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  blank,
    output logic                  carry,
    output logic                  bcd_err
);

    localparam int IDX_W = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [4*DIGITS-1:0] r_count;
    logic [IDX_W-1:0]    r_idx;
    logic [PRE_W-1:0]    r_pre;
    logic [3:0]          r_digit;
    logic [DIGITS-1:0]   r_digit_sel;
    logic                r_blank;
    logic                r_carry;
    logic                r_bcd_err;

    logic [4*DIGITS-1:0] w_load_val;
    logic                w_load_bad;
    logic [4*DIGITS-1:0] w_inc_val;
    logic                w_wrap;
    logic [3:0]          w_cur;
    logic [DIGITS-1:0]   w_onehot;
    logic                w_upper_nz;
    logic                w_blank;

    // Sanitise the load value: nibbles above 9 become 0 and are flagged.
    always_comb begin
        w_load_val = '0;
        w_load_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (load_bcd[k*4 +: 4] > 4'd9) begin
                w_load_bad = 1'b1;
            end else begin
                w_load_val[k*4 +: 4] = load_bcd[k*4 +: 4];
            end
        end
    end

    // Ripple BCD increment; a carry out of the top digit means all-9s wrapped.
    always_comb begin
        w_inc_val = r_count;
        w_wrap    = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_wrap) begin
                if (r_count[k*4 +: 4] == 4'd9) begin
                    w_inc_val[k*4 +: 4] = 4'd0;
                end else begin
                    w_inc_val[k*4 +: 4] = r_count[k*4 +: 4] + 4'd1;
                    w_wrap              = 1'b0;
                end
            end
        end
    end

    // Select the scanned digit and decide whether it is a leading zero.
    always_comb begin
        w_cur      = 4'd0;
        w_onehot   = '0;
        w_upper_nz = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (k == int'(r_idx)) begin
                w_cur       = r_count[k*4 +: 4];
                w_onehot[k] = 1'b1;
            end
            if ((k >= int'(r_idx)) && (r_count[k*4 +: 4] != 4'd0)) begin
                w_upper_nz = 1'b1;
            end
        end
        w_blank = (BLANK_LZ != 0) && (r_idx != '0) && !w_upper_nz;
    end

    // Count register with clr > load > inc > hold priority, carry and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_carry   <= 1'b0;
            r_bcd_err <= 1'b0;
        end else begin
            r_carry <= 1'b0;
            if (clr) begin
                r_count   <= '0;
                r_bcd_err <= 1'b0;
            end else if (load) begin
                r_count <= w_load_val;
                if (w_load_bad) begin
                    r_bcd_err <= 1'b1;
                end
            end else if (inc) begin
                r_count <= w_inc_val;
                r_carry <= w_wrap;
            end
        end
    end

    // Scan prescaler and digit index; independent of the count controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
            r_pre <= '0;
            if (r_idx == IDX_W'(DIGITS - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Registered display outputs; a blanked digit drives no select and code 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit     <= 4'd0;
            r_digit_sel <= '0;
            r_blank     <= 1'b1;
        end else begin
            r_blank     <= w_blank;
            r_digit     <= w_blank ? 4'd0 : w_cur;
            r_digit_sel <= w_blank ? '0   : w_onehot;
        end
    end

    assign digit     = r_digit;
    assign digit_sel = r_digit_sel;
    assign blank     = r_blank;
    assign carry     = r_carry;
    assign bcd_err   = r_bcd_err;

endmodule

// File: tb/tb_ss_digit_scanner.sv
// Bench for ss_digit_scanner: two instances (leading-zero blanking on and off)
// share the same stimulus and are compared against a decimal-arithmetic model.
module tb_ss_digit_scanner;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int MAXV     = 9999;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                clr;
    logic                load;
    logic [4*DIGITS-1:0] load_bcd;
    logic                inc;

    logic [3:0]        digit_a,  digit_b;
    logic [DIGITS-1:0] sel_a,    sel_b;
    logic              blank_a,  blank_b;
    logic              carry_a,  carry_b;
    logic              err_a,    err_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: count as a plain decimal number, cycles since reset release.
    int   m_val;
    int   m_tick;
    bit   m_err;
    logic [3:0]        e_digit_a, e_digit_b;
    logic [DIGITS-1:0] e_sel_a,   e_sel_b;
    logic              e_blank_a;
    logic              e_carry;

    logic [7:0] exp_q[$];

    ss_digit_scanner #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) dut_lz (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bcd(load_bcd), .inc(inc),
        .digit(digit_a), .digit_sel(sel_a), .blank(blank_a), .carry(carry_a), .bcd_err(err_a)
    );

    ss_digit_scanner #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_bcd(load_bcd), .inc(inc),
        .digit(digit_b), .digit_sel(sel_b), .blank(blank_b), .carry(carry_b), .bcd_err(err_b)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_val     = 0;
        m_tick    = 0;
        m_err     = 1'b0;
        e_digit_a = 4'd0;
        e_digit_b = 4'd0;
        e_sel_a   = '0;
        e_sel_b   = '0;
        e_blank_a = 1'b1;
        e_carry   = 1'b0;
    endtask

    // One rising edge of the model: outputs from pre-edge state, then update.
    task automatic model_edge();
        int idx, p, d, lv;
        bit bad;
        idx = (m_tick / SCAN_DIV) % DIGITS;
        p   = 10 ** idx;
        d   = (m_val / p) % 10;
        e_blank_a = (idx != 0) && (m_val < p);
        e_digit_a = e_blank_a ? 4'd0 : 4'(d);
        e_sel_a   = e_blank_a ? '0 : DIGITS'(1 << idx);
        e_digit_b = 4'(d);
        e_sel_b   = DIGITS'(1 << idx);
        e_carry   = 1'b0;
        if (clr) begin
            m_val = 0;
            m_err = 1'b0;
        end else if (load) begin
            lv  = 0;
            bad = 1'b0;
            for (int k = 0; k < DIGITS; k++) begin
                int nib;
                nib = int'(load_bcd[k*4 +: 4]);
                if (nib > 9) bad = 1'b1;
                else lv += nib * (10 ** k);
            end
            m_val = lv;
            if (bad) m_err = 1'b1;
        end else if (inc) begin
            if (m_val == MAXV) begin
                m_val   = 0;
                e_carry = 1'b1;
            end else begin
                m_val++;
            end
        end
        m_tick++;
    endtask

    task automatic compare_all();
        chk("lz_digit", 32'(digit_a), 32'(e_digit_a));
        chk("lz_sel",   32'(sel_a),   32'(e_sel_a));
        chk("lz_blank", 32'(blank_a), 32'(e_blank_a));
        chk("lz_carry", 32'(carry_a), 32'(e_carry));
        chk("lz_err",   32'(err_a),   32'(m_err));
        chk("nz_digit", 32'(digit_b), 32'(e_digit_b));
        chk("nz_sel",   32'(sel_b),   32'(e_sel_b));
        chk("nz_blank", 32'(blank_b), 32'(0));
        chk("nz_carry", 32'(carry_b), 32'(e_carry));
        chk("nz_err",   32'(err_b),   32'(m_err));
    endtask

    // Driver: one clock with current inputs, then check outputs #1 after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic c, input logic l, input logic [4*DIGITS-1:0] v, input logic i);
        clr      = c;
        load     = l;
        load_bcd = v;
        inc      = i;
    endtask

    initial begin
        int t_d[4];
        logic [3:0] t_s[4];
        int held;
        int guard;
        t_d = '{3, 2, 1, 4};
        t_s = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digit", 32'(digit_a), 32'd0);
        chk("rst_sel",   32'(sel_a),   32'd0);
        chk("rst_blank", 32'(blank_a), 32'd1);
        chk("rst_carry", 32'(carry_a), 32'd0);
        chk("rst_err",   32'(err_a),   32'd0);

        // Load 1234 on the first cycle after release, then observe a full pass.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 16'h1234, 1'b0);
        step();
        drive(1'b0, 1'b0, '0, 1'b0);
        repeat (3) step();
        for (int g = 0; g < 4; g++)
            for (int r = 0; r < SCAN_DIV; r++)
                exp_q.push_back({4'(t_d[g]), t_s[g]});
        for (int n = 0; n < 16; n++) begin
            logic [7:0] e;
            step();
            e = exp_q.pop_front();
            chk("scan1234_digit", 32'(digit_a), 32'(e[7:4]));
            chk("scan1234_sel",   32'(sel_a),   32'(e[3:0]));
            chk("scan1234_blank", 32'(blank_a), 32'd0);
        end

        // 0009 + 1 -> 0010
        drive(1'b0, 1'b1, 16'h0009, 1'b0); step();
        drive(1'b0, 1'b0, '0, 1'b1);       step();
        drive(1'b0, 1'b0, '0, 1'b0);
        repeat (20) step();

        // 9999 + 1 wraps with a single carry pulse
        drive(1'b0, 1'b1, 16'h9999, 1'b0); step();
        drive(1'b0, 1'b0, '0, 1'b1);       step();
        chk("wrap_carry_hi", 32'(carry_a), 32'd1);
        drive(1'b0, 1'b0, '0, 1'b0);       step();
        chk("wrap_carry_lo", 32'(carry_a), 32'd0);
        repeat (16) step();
        // clr beats inc at 9999: no carry
        drive(1'b0, 1'b1, 16'h9999, 1'b0); step();
        drive(1'b1, 1'b0, '0, 1'b1);       step();
        chk("clr_inc_carry", 32'(carry_a), 32'd0);
        drive(1'b0, 1'b0, '0, 1'b0);
        repeat (16) step();

        // 0042: blanked upper digits on the LZ instance, shown on the other
        drive(1'b0, 1'b1, 16'h0042, 1'b0); step();
        drive(1'b0, 1'b0, '0, 1'b0);
        repeat (20) step();

        // Invalid nibble handling and sticky error
        drive(1'b0, 1'b1, 16'h0A05, 1'b0); step();
        chk("err_set", 32'(err_a), 32'd1);
        drive(1'b0, 1'b1, 16'h0001, 1'b0); step();
        chk("err_sticky", 32'(err_a), 32'd1);
        drive(1'b0, 1'b0, '0, 1'b0); repeat (4) step();
        drive(1'b1, 1'b0, '0, 1'b0); step();
        chk("err_clr", 32'(err_a), 32'd0);
        drive(1'b0, 1'b0, '0, 1'b0); repeat (4) step();

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [4*DIGITS-1:0] v;
            r = $urandom_range(0, 99);
            for (int k = 0; k < DIGITS; k++)
                v[k*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) v = 16'h9990 | 16'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
            drive(r < 3, (r >= 3) && (r < 12), v, $urandom_range(0, 2) != 0);
            step();
        end
        drive(1'b0, 1'b0, '0, 1'b0);

        // Asynchronous reset in the middle of digit 2's dwell
        drive(1'b0, 1'b1, 16'h0777, 1'b0); step();
        drive(1'b0, 1'b0, '0, 1'b0);
        guard = 0;
        while (!((((m_tick / SCAN_DIV) % DIGITS) == 2) && ((m_tick % SCAN_DIV) == 2)) && guard < 64) begin
            step();
            guard++;
        end
        chk("reach_digit2", 32'(guard < 64), 32'd1);
        chk("pre_rst_sel", 32'(sel_a), 32'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_sel",   32'(sel_a),   32'd0);
        chk("async_blank", 32'(blank_a), 32'd1);
        chk("async_digit", 32'(digit_a), 32'd0);
        chk("async_err",   32'(err_a),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        held = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (sel_a == 4'b0001 && digit_a == 4'd0) held++;
        end
        chk("post_rst_dwell", 32'(held), 32'(SCAN_DIV));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
